// File: rtl/io_out_pacer.sv
// rtl/io_out_pacer.sv - FIFO-buffered pad output stage holding each value >= HOLD_CYCLES cycles.
// Optional toggle_o output enabled by macro IO_PACER_TOGGLE_EN.
module io_out_pacer #(
  parameter int               OUT_W       = 16,
  parameter int               DEPTH       = 4,
  parameter int               HOLD_CYCLES = 1000,
  parameter logic [OUT_W-1:0] RESET_VAL   = '0
) (
  input  logic                     wb_clk_i,
  input  logic                     wb_rst_i,
  input  logic                     wr_valid_i,
  input  logic [OUT_W-1:0]         wr_data_i,
  output logic                     wr_ready_o,
  input  logic                     clr_i,
  output logic [OUT_W-1:0]         out_data_o,
  output logic                     out_strobe_o,
  output logic [OUT_W-1:0]         io_oeb_o,
  output logic [$clog2(DEPTH):0]   level_o,
  output logic                     busy_o,
`ifdef IO_PACER_TOGGLE_EN
  output logic                     overflow_o,
  output logic                     toggle_o
`else
  output logic                     overflow_o
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [CW-1:0] HOLD_LOAD = CW'(HOLD_CYCLES - 1);
  localparam logic [AW:0]   FULL_LVL  = (AW+1)'(DEPTH);

  typedef enum logic {IDLE, HOLD} state_t;

  state_t            state, state_next;
  logic [CW-1:0]     cnt, cnt_next;
  logic [OUT_W-1:0]  mem [DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [AW:0]       level;
  logic [OUT_W-1:0]  out_data;
  logic              strobe, oe, ovf;
  logic              full, push, pop;

  assign full = (level == FULL_LVL);
  // Full is judged on registered occupancy, so a same-cycle pop never frees a slot.
  assign push = wr_valid_i & ~full & ~clr_i;

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    pop        = 1'b0;
    case (state)
      IDLE: begin
        if (level != '0) begin
          pop        = 1'b1;
          state_next = HOLD;
          cnt_next   = HOLD_LOAD;
        end
      end
      HOLD: begin
        if (cnt != '0) begin
          cnt_next = cnt - 1'b1;
        end else if (level != '0) begin
          pop      = 1'b1;
          cnt_next = HOLD_LOAD;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
    if (clr_i) begin
      pop        = 1'b0;
      state_next = IDLE;
      cnt_next   = '0;
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (push) mem[wr_ptr] <= wr_data_i;
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      out_data <= RESET_VAL;
      strobe   <= 1'b0;
      oe       <= 1'b0;
      ovf      <= 1'b0;
    end else if (clr_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      strobe <= 1'b0;
      ovf    <= 1'b0;
    end else begin
      strobe <= pop;
      if (wr_valid_i & full) ovf <= 1'b1;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr   <= rd_ptr + 1'b1;
        out_data <= mem[rd_ptr];
        oe       <= 1'b1;
      end
      if (push & ~pop)      level <= level + (AW+1)'(1);
      else if (pop & ~push) level <= level - (AW+1)'(1);
    end
  end

`ifdef IO_PACER_TOGGLE_EN
  logic tog;
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i)  tog <= 1'b0;
    else if (pop)  tog <= ~tog;
  end
  assign toggle_o = tog;
`endif

  assign wr_ready_o   = ~full;
  assign out_data_o   = out_data;
  assign out_strobe_o = strobe;
  assign io_oeb_o     = {OUT_W{~oe}};
  assign level_o      = level;
  assign busy_o       = (level != '0) | (state == HOLD);
  assign overflow_o   = ovf;

endmodule
